pme_wake_gen: RTL

PME_WAKE_GEN -- requirements
Module: pme_wake_gen

---
 rtl/pme_wake_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pme_wake_gen.sv
// rtl/pme_wake_gen.sv - PME#/WAKE# assertion generator with sticky status, rearm and retry counting
module pme_wake_gen #(
    parameter int         CNT_W     = 8,
    parameter logic [3:0] RETRY_MAX = 4'd15
) (
    input  logic             clk,
    input  logic             pgoodaux,
    input  logic             t1ms_tick,
    input  logic             pme_event_pls,
    input  logic             pme_en,
    input  logic             pme_sts_clr,
    input  logic [3:0]       pulse_width,
    input  logic [7:0]       rearm_period,
    output logic             pme_drv_n,
    output logic             pme_sts,
    output logic [CNT_W-1:0] event_cnt,
    output logic [3:0]       retry_cnt,
    output logic [1:0]       pme_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_UNUSED   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       width_q, width_d;
    logic [7:0]       rearm_q, rearm_d;
    logic             sts_q, sts_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic [3:0]       retry_q, retry_d;
    logic             drv_n_q, drv_n_d;

    logic             ev_acc;
    logic [3:0]       width_load;
    logic [CNT_W-1:0] evt_inc;
    logic [3:0]       retry_inc;

    assign ev_acc     = pme_event_pls & pme_en;
    assign width_load = (pulse_width == 4'd0) ? 4'd1 : pulse_width;
    assign evt_inc    = (evt_q == {CNT_W{1'b1}}) ? evt_q : evt_q + CNT_W'(1);
    assign retry_inc  = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 4'd1;

    // Status/counter updates and FSM next state; enable loss and clear dominate the state walk
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        rearm_d = rearm_q;
        sts_d   = sts_q;
        evt_d   = evt_q;
        retry_d = retry_q;

        if (pme_sts_clr) begin
            sts_d   = 1'b0;
            evt_d   = '0;
            retry_d = 4'd0;
        end
        if (ev_acc) begin
            sts_d = 1'b1;
            evt_d = pme_sts_clr ? CNT_W'(1) : evt_inc;
        end

        if (!pme_en) begin
            state_d = ST_IDLE;
        end else if (pme_sts_clr) begin
            if (ev_acc) begin
                state_d = ST_ASSERT;
                width_d = width_load;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_acc || sts_q) begin
                        state_d = ST_ASSERT;
                        width_d = width_load;
                    end
                end
                ST_ASSERT: begin
                    if (t1ms_tick) begin
                        if (width_q <= 4'd1) begin
                            state_d = ST_WAIT_ACK;
                            width_d = 4'd0;
                            rearm_d = rearm_period;
                        end else begin
                            width_d = width_q - 4'd1;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    // A zero rearm count means re-assertion is disabled: park here
                    if (t1ms_tick && (rearm_q != 8'd0)) begin
                        if (rearm_q == 8'd1) begin
                            state_d = ST_ASSERT;
                            width_d = width_load;
                            rearm_d = 8'd0;
                            retry_d = retry_inc;
                        end else begin
                            rearm_d = rearm_q - 8'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        drv_n_d = (state_d != ST_ASSERT);
    end

    // State and output registers; reset releases the pin without waiting for a clock
    always_ff @(posedge clk or negedge pgoodaux) begin
        if (!pgoodaux) begin
            state_q <= ST_IDLE;
            width_q <= 4'd0;
            rearm_q <= 8'd0;
            sts_q   <= 1'b0;
            evt_q   <= '0;
            retry_q <= 4'd0;
            drv_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            rearm_q <= rearm_d;
            sts_q   <= sts_d;
            evt_q   <= evt_d;
            retry_q <= retry_d;
            drv_n_q <= drv_n_d;
        end
    end

    assign pme_drv_n = drv_n_q;
    assign pme_sts   = sts_q;
    assign event_cnt = evt_q;
    assign retry_cnt = retry_q;
    assign pme_state = state_q;

endmodule
